// File: rtl/taxi_eth_mac_stat_accum_if.sv
// AXI4-Stream bundle shared by the MAC statistics path.
// Optional sidebands are always present; producers tie off the ones they disable.
interface taxi_axis_if #(
    parameter int DATA_W  = 8,
    parameter bit KEEP_EN = 1'b1,
    parameter int KEEP_W  = (DATA_W + 7) / 8,
    parameter bit LAST_EN = 1'b1,
    parameter bit ID_EN   = 1'b0,
    parameter int ID_W    = 8,
    parameter bit DEST_EN = 1'b0,
    parameter int DEST_W  = 8,
    parameter bit USER_EN = 1'b0,
    parameter int USER_W  = 1
) ();
    logic [DATA_W-1:0] tdata;
    logic [KEEP_W-1:0] tkeep;
    logic              tvalid;
    logic              tready;
    logic              tlast;
    logic [ID_W-1:0]   tid;
    logic [DEST_W-1:0] tdest;
    logic [USER_W-1:0] tuser;

    modport master (output tdata, tkeep, tvalid, tlast, tid, tdest, tuser, input tready);
    modport slave  (input tdata, tkeep, tvalid, tlast, tid, tdest, tuser, output tready);
endinterface

// File: rtl/taxi_eth_mac_stat_accum.sv
// Multi-channel MAC event accumulator: counts status pulses per (channel, event)
// and periodically or on flush emits non-zero counts as increment records.
module taxi_eth_mac_stat_accum #(
    parameter int CH_N          = 4,
    parameter int EV_N          = 10,
    parameter int CNT_W         = 16,
    parameter int ID_BASE       = 0,
    parameter int UPDATE_PERIOD = 1024
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [CH_N*EV_N-1:0] ev_in,
    input  logic                 flush,
    taxi_axis_if.master          m_axis_stat,
    output logic                 scan_busy
);
    localparam int N     = CH_N * EV_N;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam int TMR_W = $clog2(UPDATE_PERIOD);

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(UPDATE_PERIOD - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic [IDX_W-1:0] idx_r;
    logic [IDX_W-1:0] idx_s;
    logic [CNT_W-1:0] acc_r [N];
    logic [N-1:0]     ovf_r;
    logic [TMR_W-1:0] tmr_r;
    logic             scan_pend_r;
    logic             scan_busy_r;
    logic [CNT_W-1:0] tdata_r;
    logic [7:0]       tid_r;
    logic             tuser_r;
    logic             tvalid_r;

    logic             wrap_s;
    logic             start_s;
    logic             cap_s;
    logic             slot_free_s;
    logic             cur_nz_s;

    assign wrap_s      = (tmr_r == TMR_LAST);
    assign slot_free_s = !tvalid_r || m_axis_stat.tready;
    assign cur_nz_s    = (acc_r[idx_r] != {CNT_W{1'b0}});

    // Free-running update timer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmr_r <= {TMR_W{1'b0}};
        end else if (wrap_s) begin
            tmr_r <= {TMR_W{1'b0}};
        end else begin
            tmr_r <= tmr_r + TMR_W'(1);
        end
    end

    // Scan request latch; a new request wins over the clear on scan start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_pend_r <= 1'b0;
        end else begin
            scan_pend_r <= wrap_s || flush || (scan_pend_r && !start_s);
        end
    end

    // Scan FSM next state: a stalled index holds until the output slot frees
    always_comb begin
        state_s = state_r;
        idx_s   = idx_r;
        start_s = 1'b0;
        cap_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (scan_pend_r) begin
                    start_s = 1'b1;
                    idx_s   = {IDX_W{1'b0}};
                    state_s = SCAN;
                end else begin
                    state_s = IDLE;
                end
            end
            SCAN: begin
                cap_s = cur_nz_s && slot_free_s;
                if (!cur_nz_s || slot_free_s) begin
                    if (idx_r == IDX_LAST) begin
                        state_s = IDLE;
                    end else begin
                        idx_s = idx_r + IDX_W'(1);
                    end
                end else begin
                    idx_s = idx_r;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // FSM state, scan index and busy flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            idx_r       <= {IDX_W{1'b0}};
            scan_busy_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            idx_r       <= idx_s;
            scan_busy_r <= (state_s == SCAN);
        end
    end

    // Saturating accumulators; the captured slot restarts from this cycle's event
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                acc_r[i] <= {CNT_W{1'b0}};
            end
            ovf_r <= {N{1'b0}};
        end else begin
            for (int i = 0; i < N; i++) begin
                if (cap_s && (idx_r == IDX_W'(i))) begin
                    acc_r[i] <= CNT_W'(ev_in[i]);
                    ovf_r[i] <= 1'b0;
                end else if (ev_in[i]) begin
                    if (acc_r[i] == CNT_MAX) begin
                        ovf_r[i] <= 1'b1;
                    end else begin
                        acc_r[i] <= acc_r[i] + CNT_W'(1);
                    end
                end else begin
                    acc_r[i] <= acc_r[i];
                end
            end
        end
    end

    // Output register: payload only changes when a new record loads
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tdata_r  <= {CNT_W{1'b0}};
            tid_r    <= 8'd0;
            tuser_r  <= 1'b0;
            tvalid_r <= 1'b0;
        end else if (cap_s) begin
            tdata_r  <= acc_r[idx_r];
            tid_r    <= 8'(ID_BASE) + 8'(idx_r);
            tuser_r  <= ovf_r[idx_r];
            tvalid_r <= 1'b1;
        end else if (m_axis_stat.tready) begin
            tvalid_r <= 1'b0;
        end else begin
            tvalid_r <= tvalid_r;
        end
    end

    assign m_axis_stat.tdata  = tdata_r;
    assign m_axis_stat.tkeep  = '1;
    assign m_axis_stat.tvalid = tvalid_r;
    assign m_axis_stat.tlast  = 1'b1;
    assign m_axis_stat.tid    = tid_r;
    assign m_axis_stat.tdest  = '0;
    assign m_axis_stat.tuser  = tuser_r;
    assign scan_busy          = scan_busy_r;
endmodule

// File: tb/tb_taxi_eth_mac_stat_accum.sv
// Bench for taxi_eth_mac_stat_accum: directed scenarios plus a running
// event-conservation model that predicts every emitted record.
module tb_taxi_eth_mac_stat_accum;
    localparam int N      = 40;
    localparam int CNT_W  = 6;
    localparam int MAXV   = 63;
    localparam int PERIOD = 512;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic [N-1:0] ev_in = '0;
    logic         flush = 1'b0;
    logic         scan_busy;

    taxi_axis_if #(.DATA_W(CNT_W), .KEEP_EN(1'b0), .LAST_EN(1'b0), .ID_EN(1'b1),
                   .ID_W(8), .USER_EN(1'b1), .USER_W(1)) stat_if ();

    taxi_eth_mac_stat_accum #(.CH_N(4), .EV_N(10), .CNT_W(CNT_W), .ID_BASE(0),
                              .UPDATE_PERIOD(PERIOD)) dut (
        .clk(clk), .rst_n(rst_n), .ev_in(ev_in), .flush(flush),
        .m_axis_stat(stat_if), .scan_busy(scan_busy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    typedef struct { int tid; int data; int user; } beat_t;
    beat_t acc_q[$];

    // Reference model: events applied since the last capture, per index
    int cnt [N];
    logic [N-1:0] ev_prev;
    logic p_valid, p_ready, p_user;
    logic [CNT_W-1:0] p_data;
    logic [7:0] p_tid;
    int last_tid;
    int mt, exp_d;
    logic exp_u, new_beat;

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                foreach (cnt[i]) cnt[i] = 0;
                ev_prev = '0; p_valid = 1'b0; p_ready = 1'b0; last_tid = -1;
            end else begin
                new_beat = 1'b0; mt = -1;
                if (p_valid && !p_ready) begin
                    checks++;
                    if (stat_if.tvalid !== 1'b1 || stat_if.tdata !== p_data ||
                        stat_if.tid !== p_tid || stat_if.tuser !== p_user) begin
                        errors++;
                        $display("FAIL hold_stable: got v=%b d=%0d id=%0d u=%b, required v=1 d=%0d id=%0d u=%b",
                                 stat_if.tvalid, stat_if.tdata, stat_if.tid, stat_if.tuser, p_data, p_tid, p_user);
                    end
                end else if (stat_if.tvalid === 1'b1) begin
                    mt = int'(stat_if.tid);
                    checks++;
                    if (mt >= N) begin
                        errors++;
                        $display("FAIL beat_tid_range: got tid=%0d, required < %0d", mt, N);
                    end else begin
                        new_beat = 1'b1;
                        exp_d = (cnt[mt] > MAXV) ? MAXV : cnt[mt];
                        exp_u = (cnt[mt] > MAXV);
                        if (cnt[mt] == 0 || int'(stat_if.tdata) != exp_d || stat_if.tuser !== exp_u) begin
                            errors++;
                            $display("FAIL beat_value tid=%0d: got d=%0d u=%b, required d=%0d u=%b (nonzero)",
                                     mt, stat_if.tdata, stat_if.tuser, exp_d, exp_u);
                        end
                        checks++;
                        if (mt <= last_tid) begin
                            errors++;
                            $display("FAIL beat_order: got tid=%0d, required > %0d", mt, last_tid);
                        end
                        last_tid = mt;
                    end
                end
                for (int i = 0; i < N; i++) begin
                    if (new_beat && i == mt) cnt[i] = int'(ev_prev[i]);
                    else cnt[i] += int'(ev_prev[i]);
                end
                if (scan_busy !== 1'b1) last_tid = -1;
                if (stat_if.tvalid === 1'b1 && stat_if.tready === 1'b1)
                    acc_q.push_back('{int'(stat_if.tid), int'(stat_if.tdata), int'(stat_if.tuser)});
                ev_prev = ev_in;
                p_valid = stat_if.tvalid; p_ready = stat_if.tready;
                p_data = stat_if.tdata; p_tid = stat_if.tid; p_user = stat_if.tuser;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    task automatic wait_quiet(input int budget);
        int n = 0;
        repeat (3) tick();
        while ((scan_busy !== 1'b0 || stat_if.tvalid !== 1'b0) && n < budget) begin
            tick(); n++;
        end
        if (scan_busy !== 1'b0 || stat_if.tvalid !== 1'b0) begin
            checks++; errors++;
            $display("FAIL quiet_timeout: got busy=%b tvalid=%b, required 0 0", scan_busy, stat_if.tvalid);
        end
    endtask

    task automatic wait_beat(input int budget, output beat_t b);
        int n = 0;
        while (acc_q.size() == 0 && n < budget) begin
            tick(); n++;
        end
        if (acc_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL beat_timeout: got no record in %0d cycles, required one", budget);
            b = '{-1, -1, -1};
        end else begin
            b = acc_q.pop_front();
        end
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        repeat (3) tick();
        checks++;
        if (stat_if.tvalid !== 1'b0 || scan_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got tvalid=%b busy=%b, required 0 0", stat_if.tvalid, scan_busy);
        end
        checks++;
        if (stat_if.tdata !== '0 || stat_if.tid !== 8'd0 || stat_if.tuser !== 1'b0) begin
            errors++;
            $display("FAIL reset_data: got d=%0d id=%0d u=%b, required 0 0 0", stat_if.tdata, stat_if.tid, stat_if.tuser);
        end
        rst_n = 1'b1;
        stat_if.tready = 1'b1;
    endtask

    task automatic test_timer();
        int t1 = -1, t2 = -1, n = 0;
        logic prev = scan_busy;
        while (t2 < 0 && n < 1500) begin
            tick(); n++;
            if (scan_busy === 1'b1 && prev === 1'b0) begin
                if (t1 < 0) t1 = n; else t2 = n;
            end
            prev = scan_busy;
        end
        checks++;
        if (t2 < 0 || t2 - t1 != PERIOD) begin
            errors++;
            $display("FAIL timer_period: got %0d (t1=%0d t2=%0d), required %0d", t2 - t1, t1, t2, PERIOD);
        end
    endtask

    task automatic test_double_flush();
        int n = 0, low = 0, rises = 0;
        logic prev;
        tick(); pulse_flush();
        repeat (5) tick();
        pulse_flush();
        while (scan_busy === 1'b1 && n < 100) begin tick(); n++; end
        while (scan_busy === 1'b0 && low < 100) begin tick(); low++; end
        checks++;
        if (low != 1) begin
            errors++;
            $display("FAIL dflush_gap: got %0d idle cycles, required 1", low);
        end
        n = 0;
        while (scan_busy === 1'b1 && n < 100) begin tick(); n++; end
        prev = scan_busy;
        repeat (150) begin
            tick();
            if (scan_busy === 1'b1 && prev === 1'b0) rises++;
            prev = scan_busy;
        end
        checks++;
        if (rises != 0) begin
            errors++;
            $display("FAIL dflush_extra: got %0d further scans, required 0", rises);
        end
    endtask

    task automatic test_single_period();
        beat_t b;
        wait_quiet(100);
        acc_q.delete();
        ev_in[0] = 1'b1;
        repeat (3) tick();
        ev_in[0] = 1'b0;
        wait_beat(PERIOD + 100, b);
        checks++;
        if (b.tid != 0 || b.data != 3 || b.user != 0) begin
            errors++;
            $display("FAIL single_beat: got tid=%0d d=%0d u=%0d, required 0 3 0", b.tid, b.data, b.user);
        end
        repeat (PERIOD + 88) tick();
        checks++;
        if (acc_q.size() != 0) begin
            errors++;
            $display("FAIL single_repeat: got %0d extra records, required 0", acc_q.size());
        end
    endtask

    task automatic test_saturate();
        beat_t b;
        wait_quiet(100);
        acc_q.delete();
        ev_in[25] = 1'b1;
        repeat (70) tick();
        ev_in[25] = 1'b0;
        pulse_flush();
        wait_beat(200, b);
        checks++;
        if (b.tid != 25 || b.data != MAXV || b.user != 1) begin
            errors++;
            $display("FAIL sat_beat: got tid=%0d d=%0d u=%0d, required 25 %0d 1", b.tid, b.data, b.user, MAXV);
        end
        wait_quiet(100);
        ev_in[25] = 1'b1;
        repeat (2) tick();
        ev_in[25] = 1'b0;
        pulse_flush();
        wait_beat(200, b);
        checks++;
        if (b.tid != 25 || b.data != 2 || b.user != 0) begin
            errors++;
            $display("FAIL sat_after: got tid=%0d d=%0d u=%0d, required 25 2 0", b.tid, b.data, b.user);
        end
    endtask

    task automatic test_backpressure();
        beat_t b;
        int n = 0;
        wait_quiet(100);
        acc_q.delete();
        stat_if.tready = 1'b0;
        ev_in[3] = 1'b1; ev_in[12] = 1'b1;
        repeat (2) tick();
        ev_in[3] = 1'b0;
        repeat (3) tick();
        ev_in[12] = 1'b0;
        pulse_flush();
        while (stat_if.tvalid !== 1'b1 && n < 60) begin tick(); n++; end
        repeat (10) begin
            tick();
            checks++;
            if (stat_if.tvalid !== 1'b1 || stat_if.tdata !== 6'd2 || stat_if.tid !== 8'd3 || scan_busy !== 1'b1) begin
                errors++;
                $display("FAIL bp_hold: got v=%b d=%0d id=%0d busy=%b, required 1 2 3 1",
                         stat_if.tvalid, stat_if.tdata, stat_if.tid, scan_busy);
            end
        end
        stat_if.tready = 1'b1;
        wait_beat(100, b);
        checks++;
        if (b.tid != 3 || b.data != 2) begin
            errors++;
            $display("FAIL bp_first: got tid=%0d d=%0d, required 3 2", b.tid, b.data);
        end
        wait_beat(100, b);
        checks++;
        if (b.tid != 12 || b.data != 5 || scan_busy !== 1'b1) begin
            errors++;
            $display("FAIL bp_second: got tid=%0d d=%0d busy=%b, required 12 5 1", b.tid, b.data, scan_busy);
        end
    endtask

    task automatic test_continuous();
        int sum = 0, sat = 0;
        wait_quiet(100);
        acc_q.delete();
        ev_in[7] = 1'b1;
        repeat (400) begin
            stat_if.tready = 1'($urandom_range(0, 1));
            flush = ($urandom_range(0, 9) == 0);
            tick();
        end
        ev_in[7] = 1'b0; flush = 1'b0; stat_if.tready = 1'b1;
        pulse_flush(); wait_quiet(200);
        pulse_flush(); wait_quiet(200);
        foreach (acc_q[i]) begin
            if (acc_q[i].tid == 7) begin
                sum += acc_q[i].data;
                sat += acc_q[i].user;
            end
        end
        checks++;
        if (sum != 400 || sat != 0) begin
            errors++;
            $display("FAIL cont_sum: got sum=%0d sat=%0d, required 400 0", sum, sat);
        end
    endtask

    task automatic test_random();
        repeat (1500) begin
            for (int i = 0; i < N; i++) ev_in[i] = ($urandom_range(0, 15) == 0);
            stat_if.tready = ($urandom_range(0, 9) < 7);
            flush = ($urandom_range(0, 49) == 0);
            tick();
        end
        ev_in = '0; flush = 1'b0; stat_if.tready = 1'b1;
        pulse_flush(); wait_quiet(400);
        pulse_flush(); wait_quiet(400);
    endtask

    task automatic test_reset_mid();
        beat_t b;
        int n = 0;
        wait_quiet(100);
        stat_if.tready = 1'b0;
        ev_in[5] = 1'b1; tick(); ev_in[5] = 1'b0;
        pulse_flush();
        while (stat_if.tvalid !== 1'b1 && n < 60) begin tick(); n++; end
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if (stat_if.tvalid !== 1'b0 || scan_busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid: got tvalid=%b busy=%b, required 0 0", stat_if.tvalid, scan_busy);
        end
        repeat (2) tick();
        rst_n = 1'b1;
        stat_if.tready = 1'b1;
        tick();
        acc_q.delete();
        pulse_flush(); wait_quiet(100);
        checks++;
        if (acc_q.size() != 0) begin
            errors++;
            $display("FAIL rst_replay: got %0d records, required 0", acc_q.size());
        end
        ev_in[9] = 1'b1; tick(); ev_in[9] = 1'b0;
        pulse_flush();
        wait_beat(100, b);
        checks++;
        if (b.tid != 9 || b.data != 1 || b.user != 0) begin
            errors++;
            $display("FAIL rst_new: got tid=%0d d=%0d u=%0d, required 9 1 0", b.tid, b.data, b.user);
        end
    endtask

    task automatic test_residual();
        int left = 0;
        ev_in = '0;
        pulse_flush(); wait_quiet(200);
        foreach (cnt[i]) if (cnt[i] != 0) left++;
        checks++;
        if (left != 0) begin
            errors++;
            $display("FAIL residual: got %0d indices with unreported events, required 0", left);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        stat_if.tready = 1'b0;
        test_reset();
        test_timer();
        test_double_flush();
        test_single_period();
        test_saturate();
        test_backpressure();
        test_continuous();
        test_reset_mid();
        test_random();
        test_residual();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
